// File: rtl/dpll_step_sequencer.sv
// dpll_step_sequencer: steps the DPLL core through NUM_STEPS tuning words.
// For each setpoint it programs the tuning word, waits for stable lock, dwells,
// then moves on. A settle timeout latches a fault until enable drops.
// Optional build macro: DPLL_SEQ_PINGPONG_EN (bounce the sweep instead of wrapping).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | sweep disabled, step index parked at 0
// LOAD     | compute and present the tuning word, restart the settle timer
// WAIT_ACK | cfg_valid held until the DPLL acknowledges the tuning word
// SETTLE   | counting consecutive lock cycles, settle timer still running
// DWELL    | locked; holding the setpoint for DWELL_CYCLES
// NEXT     | advance the step index, toggle the step LED
// FAULT    | settle/ack timeout latched, waiting for enable to drop
module dpll_step_sequencer #(
   parameter int               FTW_W        = 24,
   parameter int               NUM_STEPS    = 5,
   parameter logic [FTW_W-1:0] FTW_BASE     = FTW_W'(24'h100000),
   parameter logic [FTW_W-1:0] FTW_STEP     = FTW_W'(24'h001000),
   parameter int               LOCK_HOLD    = 64,
   parameter int               SETTLE_MAX   = 12000,
   parameter int               DWELL_CYCLES = 24000
) (
   input  logic             clk_12MHz,
   input  logic             reset,
   input  logic             enable,
   input  logic             lock_in,
   input  logic             cfg_ack,
   output logic             cfg_valid,
   output logic [FTW_W-1:0] cfg_ftw,
   output logic [2:0]       step_idx,
   output logic             fault,
   output logic [2:0]       leds
);

   localparam int TMR_W   = $clog2(SETTLE_MAX + 1);
   localparam int HOLD_W  = $clog2(LOCK_HOLD + 1);
   localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);

   localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(SETTLE_MAX - 1);
   localparam logic [TMR_W-1:0]   TMR_MAX    = TMR_W'(SETTLE_MAX);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(LOCK_HOLD - 1);
   localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(LOCK_HOLD);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
   localparam logic [DWELL_W-1:0] DWELL_MAX  = DWELL_W'(DWELL_CYCLES);
   localparam logic [2:0]         STEP_LAST  = 3'(NUM_STEPS - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, WAIT_ACK, SETTLE, DWELL, NEXT, FAULT
   } state_t;

   state_t             state;
   logic [TMR_W-1:0]   timer;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [DWELL_W-1:0] dwell_cnt;

   logic [TMR_W-1:0]   timer_inc;
   logic [HOLD_W-1:0]  hold_inc;
   logic [DWELL_W-1:0] dwell_inc;
   logic [FTW_W-1:0]   ftw_calc;
   logic [2:0]         next_idx;

`ifdef DPLL_SEQ_PINGPONG_EN
   logic dir_down;
   logic next_dir_down;

   // Bounce between the end indices; the end index is never repeated.
   always_comb begin
      next_idx      = step_idx;
      next_dir_down = dir_down;
      if (!dir_down) begin
         if (step_idx == STEP_LAST) begin
            next_idx      = step_idx - 3'd1;
            next_dir_down = 1'b1;
         end else begin
            next_idx = step_idx + 3'd1;
         end
      end else begin
         if (step_idx == 3'd0) begin
            next_idx      = 3'd1;
            next_dir_down = 1'b0;
         end else begin
            next_idx = step_idx - 3'd1;
         end
      end
   end
`else
   // Wrap back to step 0 after the last setpoint.
   always_comb begin
      next_idx = (step_idx == STEP_LAST) ? 3'd0 : step_idx + 3'd1;
   end
`endif

   // Saturating counter increments and the tuning word for the current step.
   always_comb begin
      timer_inc = (timer == TMR_MAX) ? timer : timer + 1'b1;
      hold_inc  = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
      dwell_inc = (dwell_cnt == DWELL_MAX) ? dwell_cnt : dwell_cnt + 1'b1;
      ftw_calc  = FTW_BASE + FTW_W'(step_idx) * FTW_STEP;
   end

   // Sequencer FSM; all outputs are registered here.
   always_ff @(posedge clk_12MHz or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cfg_valid <= 1'b0;
         cfg_ftw   <= '0;
         step_idx  <= 3'd0;
         fault     <= 1'b0;
         leds      <= 3'b000;
         timer     <= '0;
         hold_cnt  <= '0;
         dwell_cnt <= '0;
`ifdef DPLL_SEQ_PINGPONG_EN
         dir_down  <= 1'b0;
`endif
      end else if (!enable) begin
         // cfg_ftw deliberately keeps its last value
         state     <= IDLE;
         cfg_valid <= 1'b0;
         step_idx  <= 3'd0;
         fault     <= 1'b0;
         leds      <= 3'b000;
         timer     <= '0;
         hold_cnt  <= '0;
         dwell_cnt <= '0;
`ifdef DPLL_SEQ_PINGPONG_EN
         dir_down  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               step_idx <= 3'd0;
               state    <= LOAD;
            end
            LOAD: begin
               cfg_ftw   <= ftw_calc;
               cfg_valid <= 1'b1;
               timer     <= '0;
               hold_cnt  <= '0;
               state     <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (cfg_ack) begin
                  cfg_valid <= 1'b0;
                  timer     <= timer_inc;
                  state     <= SETTLE;
               end else if (timer >= TMR_LAST) begin
                  cfg_valid <= 1'b0;
                  fault     <= 1'b1;
                  leds[1]   <= 1'b1;
                  leds[0]   <= 1'b0;
                  state     <= FAULT;
               end else begin
                  timer <= timer_inc;
               end
            end
            SETTLE: begin
               // lock completing on the last timer cycle still counts as success
               if (lock_in && hold_cnt == HOLD_LAST) begin
                  leds[0]   <= 1'b1;
                  dwell_cnt <= '0;
                  state     <= DWELL;
               end else if (timer >= TMR_LAST) begin
                  cfg_valid <= 1'b0;
                  fault     <= 1'b1;
                  leds[1]   <= 1'b1;
                  leds[0]   <= 1'b0;
                  state     <= FAULT;
               end else begin
                  timer    <= timer_inc;
                  hold_cnt <= lock_in ? hold_inc : '0;
               end
            end
            DWELL: begin
               if (!lock_in) begin
                  leds[0]  <= 1'b0;
                  timer    <= '0;
                  hold_cnt <= '0;
                  state    <= SETTLE;
               end else if (dwell_cnt == DWELL_LAST) begin
                  state <= NEXT;
               end else begin
                  dwell_cnt <= dwell_inc;
               end
            end
            NEXT: begin
               leds[0]  <= 1'b0;
               leds[2]  <= ~leds[2];
               step_idx <= next_idx;
`ifdef DPLL_SEQ_PINGPONG_EN
               dir_down <= next_dir_down;
`endif
               state    <= LOAD;
            end
            FAULT: begin
               fault     <= 1'b1;
               leds[1]   <= 1'b1;
               cfg_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dpll_step_sequencer.sv
// Directed bench for dpll_step_sequencer with a scaled-down parameter set.
// Expected setpoints are queued when enable is driven and checked at each
// cfg_valid rise. Honours DPLL_SEQ_PINGPONG_EN for the expected step order.
module tb_dpll_step_sequencer;

   localparam int FTW_W = 12;

   typedef struct {
      logic [2:0]       step;
      logic [FTW_W-1:0] ftw;
   } sb_t;

   logic             clk_12MHz = 1'b0;
   logic             reset     = 1'b1;
   logic             enable    = 1'b0;
   logic             lock_in   = 1'b0;
   logic             cfg_ack   = 1'b0;
   logic             cfg_valid;
   logic [FTW_W-1:0] cfg_ftw;
   logic [2:0]       step_idx;
   logic             fault;
   logic [2:0]       leds;

   sb_t              sb_q[$];
   logic [FTW_W-1:0] last_ftw;
   int               n_chk  = 0;
   int               n_pass = 0;
   int               n_cyc;
   int               n_pops;

   dpll_step_sequencer #(
      .FTW_W        (FTW_W),
      .NUM_STEPS    (3),
      .FTW_BASE     (12'h100),
      .FTW_STEP     (12'h010),
      .LOCK_HOLD    (4),
      .SETTLE_MAX   (50),
      .DWELL_CYCLES (20)
   ) dut (
      .clk_12MHz (clk_12MHz),
      .reset     (reset),
      .enable    (enable),
      .lock_in   (lock_in),
      .cfg_ack   (cfg_ack),
      .cfg_valid (cfg_valid),
      .cfg_ftw   (cfg_ftw),
      .step_idx  (step_idx),
      .fault     (fault),
      .leds      (leds)
   );

   always #5 clk_12MHz = ~clk_12MHz;

   task automatic tick();
      @(posedge clk_12MHz);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push_exp(input logic [2:0] step);
      sb_t e;
      e.step = step;
      e.ftw  = 12'h100 + {9'd0, step} * 12'h010;
      sb_q.push_back(e);
   endtask

   task automatic pop_check(input logic exp_led2);
      sb_t e;
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         last_ftw = e.ftw;
         check("cfg_ftw", 32'(cfg_ftw), 32'(e.ftw));
         check("step_idx", 32'(step_idx), 32'(e.step));
         check("led2", 32'(leds[2]), 32'(exp_led2));
      end
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      while (cfg_valid !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check("valid_seen", 32'(cfg_valid), 32'd1);
   endtask

   task automatic ack_once();
      cfg_ack = 1'b1;
      tick();
      cfg_ack = 1'b0;
      check("valid_drop_on_ack", 32'(cfg_valid), 32'd0);
   endtask

   initial begin
      // 1: reset state, enable-to-valid latency
      tick();
      tick();
      check("rst_valid", 32'(cfg_valid), 32'd0);
      check("rst_ftw", 32'(cfg_ftw), 32'd0);
      check("rst_step", 32'(step_idx), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_leds", 32'(leds), 32'd0);
      reset = 1'b0;
      tick();
`ifdef DPLL_SEQ_PINGPONG_EN
      push_exp(3'd0); push_exp(3'd1); push_exp(3'd2);
      push_exp(3'd1); push_exp(3'd0); push_exp(3'd1);
`else
      push_exp(3'd0); push_exp(3'd1); push_exp(3'd2);
      push_exp(3'd0); push_exp(3'd1);
`endif
      n_pops = sb_q.size();
      enable = 1'b1;
      tick();
      check("valid_edge1", 32'(cfg_valid), 32'd0);
      tick();
      check("valid_edge2", 32'(cfg_valid), 32'd1);
      pop_check(1'b0);

      // 2: delayed ack, lock hold, dwell length
      for (int i = 0; i < 3; i++) begin
         tick();
         check("valid_held", 32'(cfg_valid), 32'd1);
         check("ftw_held", 32'(cfg_ftw), 32'h100);
      end
      lock_in = 1'b1;
      ack_once();
      tick(); tick(); tick();
      check("led0_before_hold", 32'(leds[0]), 32'd0);
      tick();
      check("led0_locked", 32'(leds[0]), 32'd1);
      for (int i = 0; i < 20; i++) tick();
      check("step_during_next", 32'(step_idx), 32'd0);
      check("led0_in_dwell_end", 32'(leds[0]), 32'd1);
      tick();
      check("step_after_next", 32'(step_idx), 32'd1);
      check("leds_after_next", 32'(leds), 32'b100);
      check("no_valid_in_next", 32'(cfg_valid), 32'd0);
      tick();
      check("valid_after_load", 32'(cfg_valid), 32'd1);
      pop_check(1'b1);

      // 3: rest of the sweep with automatic ack and steady lock
      for (int k = 2; k < n_pops; k++) begin
         ack_once();
         wait_valid(100, n_cyc);
         pop_check(k[0]);
      end
      enable = 1'b0;
      tick();
      check("dis_valid", 32'(cfg_valid), 32'd0);
      check("dis_step", 32'(step_idx), 32'd0);
      check("dis_leds", 32'(leds), 32'd0);
      check("dis_ftw_kept", 32'(cfg_ftw), 32'(last_ftw));

      // 4: no lock -> settle timeout
      lock_in = 1'b0;
      push_exp(3'd0);
      enable = 1'b1;
      tick();
      tick();
      pop_check(1'b0);
      cfg_ack = 1'b1;
      for (int i = 0; i < 49; i++) begin
         tick();
         cfg_ack = 1'b0;
      end
      check("fault_not_early", 32'(fault), 32'd0);
      tick();
      check("fault_set", 32'(fault), 32'd1);
      check("fault_leds", 32'(leds), 32'b010);
      check("fault_valid", 32'(cfg_valid), 32'd0);
      tick();
      check("fault_held", 32'(fault), 32'd1);
      enable = 1'b0;
      tick();
      check("fault_clear", 32'(fault), 32'd0);
      check("fault_leds_clear", 32'(leds), 32'd0);

      // 5: lock glitch during dwell restarts settle and a full dwell
      lock_in = 1'b1;
      push_exp(3'd0);
      push_exp(3'd1);
      enable = 1'b1;
      wait_valid(10, n_cyc);
      pop_check(1'b0);
      ack_once();
      tick(); tick(); tick(); tick();
      check("g_led0_locked", 32'(leds[0]), 32'd1);
      for (int i = 0; i < 5; i++) tick();
      lock_in = 1'b0;
      tick();
      lock_in = 1'b1;
      check("g_led0_drop", 32'(leds[0]), 32'd0);
      check("g_no_reload", 32'(cfg_valid), 32'd0);
      tick(); tick(); tick();
      check("g_led0_relocking", 32'(leds[0]), 32'd0);
      tick();
      check("g_led0_relocked", 32'(leds[0]), 32'd1);
      wait_valid(100, n_cyc);
      check("g_dwell_restart", 32'(n_cyc), 32'd22);
      pop_check(1'b1);

      // 6: async reset while cfg_valid is high
      #3;
      reset = 1'b1;
      #1;
      check("arst_valid", 32'(cfg_valid), 32'd0);
      check("arst_ftw", 32'(cfg_ftw), 32'd0);
      check("arst_step", 32'(step_idx), 32'd0);
      check("arst_leds", 32'(leds), 32'd0);
      enable = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      check("arst_idle", 32'(cfg_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
